// File: rtl/dct_pkg.sv
// Shared 8x8 DCT definitions: block size, cosine table, rounding and pass-control states.
package dct_pkg;

    localparam int N        = 8;
    localparam int COS_FRAC = 14;
    localparam int SHIFT    = COS_FRAC + 1;   // cosine scale plus the 1/2 of each 1-D pass
    localparam logic signed [31:0] ROUND_C = 32'sd1 <<< COS_FRAC;

    typedef enum logic [1:0] {LOAD, ROW, COL, OUT} dct_state_t;

    // COS[u][n] = round(16384 * cos((2n+1)u*pi/16)); row 0 folds C(0) = 1/sqrt2.
    function automatic logic signed [15:0] cos_coef(input logic [2:0] u, input logic [2:0] n);
        logic [6:0]         prod;
        logic [4:0]         k;
        logic [3:0]         m;
        logic               neg;
        logic signed [15:0] mag;
        // Angle in units of pi/16, folded into the first half-period.
        prod = {3'b000, n, 1'b1} * {4'b0000, u};
        k    = prod[4:0];
        if (k > 5'd16) k = 5'd0 - k;
        neg  = (k > 5'd8);
        m    = neg ? 4'(5'd16 - k) : k[3:0];
        case (m)
            4'd0:    mag = 16'sd16384;
            4'd1:    mag = 16'sd16069;
            4'd2:    mag = 16'sd15137;
            4'd3:    mag = 16'sd13623;
            4'd4:    mag = 16'sd11585;
            4'd5:    mag = 16'sd9102;
            4'd6:    mag = 16'sd6270;
            4'd7:    mag = 16'sd3196;
            default: mag = 16'sd0;
        endcase
        if (u == 3'd0) return 16'sd11585;
        return neg ? -mag : mag;
    endfunction

endpackage

// File: rtl/dct_mac.sv
// Shared multiply-accumulate for both DCT passes: 16x16 signed product, 32-bit
// accumulator, round-half-up shift, and 12-bit saturated view for the final pass.
module dct_mac
    import dct_pkg::*;
(
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               en,
    input  logic               clr,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [15:0] rnd16,
    output logic signed [11:0] sat12
);

    logic signed [31:0] acc;
    logic signed [31:0] prod;
    logic signed [31:0] rsum;
    logic signed [31:0] rnd;

    assign prod = a * b;

    // Accumulator: clr starts a new sum with the current product.
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)  acc <= '0;
        else if (en)  acc <= clr ? prod : acc + prod;
    end

    // Round half toward +inf, then clamp to the coefficient range.
    // NOTE: every output gets a value on every path, so no latches are inferred.
    always_comb begin
        rsum  = acc + ROUND_C;
        rnd   = rsum >>> SHIFT;
        rnd16 = rnd[15:0];
        if (rnd > 32'sd2047)       sat12 = 12'h7FF;
        else if (rnd < -32'sd2048) sat12 = 12'h800;
        else                       sat12 = rnd[11:0];
    end

endmodule

// File: rtl/fdct_8x8.sv
// Forward 8x8 2-D DCT: load a pixel block, row pass, column pass on one MAC, stream coefficients.
module fdct_8x8
    import dct_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 16
)(
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic [COEF_W-1:0] coef_data,
    output logic              coef_last,
    output logic              busy
);

    localparam int S_W = PIX_W + 1;
    localparam logic [S_W-1:0] LEVEL = {2'b01, {(PIX_W-1){1'b0}}};

    dct_state_t state, state_nx;
    logic [5:0] idx;      // load / output position
    logic [2:0] outer;    // row r (ROW) or column l (COL)
    logic [2:0] inner;    // frequency u (ROW) or k (COL)
    logic [3:0] step;     // 0..7 MAC, 8 writeback
    logic       ready_q;

    logic signed [S_W-1:0] pix_buf [N*N];
    logic signed [15:0]    t_buf   [N*N];
    logic signed [11:0]    f_buf   [N*N];

    logic                  pix_fire, coef_fire, wb, pass_done;
    logic [5:0]            rd_addr, wr_addr;
    logic signed [S_W-1:0] a_pix;
    logic signed [11:0]    f_out;
    logic                  mac_en, mac_clr;
    logic signed [15:0]    mac_a, mac_b, rnd16;
    logic signed [11:0]    sat12;

    assign pix_ready  = ready_q;
    assign pix_fire   = pix_valid && ready_q;
    assign coef_valid = (state == OUT);
    assign coef_fire  = coef_valid && coef_ready;
    assign coef_last  = coef_valid && (idx == 6'd63);
    assign busy       = (state != LOAD);
    assign wb         = step[3];
    assign pass_done  = wb && (inner == 3'd7) && (outer == 3'd7);

    // Operand/result addressing: ROW walks s[r][n], COL walks T[m][l] and writes F[k][l].
    always_comb begin
        rd_addr = (state == COL) ? {step[2:0], outer} : {outer, step[2:0]};
        wr_addr = (state == COL) ? {inner, outer}     : {outer, inner};
        a_pix   = pix_buf[rd_addr];
        mac_a   = (state == COL) ? t_buf[rd_addr] : 16'(a_pix);
        mac_b   = cos_coef(inner, step[2:0]);
        mac_en  = ((state == ROW) || (state == COL)) && !step[3];
        mac_clr = (step == 4'd0);
        f_out   = f_buf[idx];
        coef_data = coef_valid ? COEF_W'(f_out) : '0;
    end

    dct_mac u_mac (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (mac_en),
        .clr     (mac_clr),
        .a       (mac_a),
        .b       (mac_b),
        .rnd16   (rnd16),
        .sat12   (sat12)
    );

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= LOAD;
        else         state <= state_nx;
    end

    // Next-state logic: LOAD -> ROW -> COL -> OUT -> LOAD.
    always_comb begin
        state_nx = state;
        case (state)
            LOAD: if (pix_fire && idx == 6'd63)  state_nx = ROW;
            ROW:  if (pass_done)                 state_nx = COL;
            COL:  if (pass_done)                 state_nx = OUT;
            OUT:  if (coef_fire && idx == 6'd63) state_nx = LOAD;
            default:                             state_nx = LOAD;
        endcase
    end

    // Counters and registered pix_ready (low in reset, high one cycle after entering LOAD).
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            idx     <= '0;
            outer   <= '0;
            inner   <= '0;
            step    <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state_nx == LOAD);
            case (state)
                LOAD: if (pix_fire) idx <= idx + 6'd1;
                ROW, COL: begin
                    if (wb) begin
                        step  <= '0;
                        inner <= inner + 3'd1;
                        if (inner == 3'd7) outer <= outer + 3'd1;
                    end else begin
                        step <= step + 4'd1;
                    end
                end
                OUT: if (coef_fire) idx <= idx + 6'd1;
                default: ;
            endcase
        end
    end

    // Block buffers: level-shifted pixels, row-pass results, final coefficients.
    // NOTE: storage arrays are not reset; their contents are always rewritten before being read.
    always_ff @(posedge sys_clk) begin
        if (pix_fire)              pix_buf[idx]     <= {1'b0, pix_data} - LEVEL;
        if (state == ROW && wb)    t_buf[wr_addr]   <= rnd16;
        if (state == COL && wb)    f_buf[wr_addr]   <= sat12;
    end

endmodule

// File: doc/fdct_8x8.md
Name: fdct_8x8

Overview:
- Forward 8x8 2-D DCT; the encode-side counterpart of the team's 8x8 IDCT.
- Accepts one 8x8 block of unsigned 8-bit pixels as a raster stream and level-shifts each pixel by -128.
- Runs a row 1-D DCT pass, then a column 1-D DCT pass, on a single shared multiply-accumulate unit.
- Streams out 64 signed DCT coefficients in raster order. Its output feeds quantisation; the IDCT consumes the dequantised coefficients.

Parameters:
- PIX_W, 8: pixel width (unsigned).
- COEF_W, 16: output coefficient width (signed); must be >= 12.
- COS_FRAC, 14: fraction bits of the cosine table (16384 = 1.0); fixed, not overridable.

Ports:
- sys_clk, in, 1: clock, rising edge.
- sys_rst, in, 1: reset, asynchronous, active-high.
- pix_valid, in, 1: pix_data is valid.
- pix_ready, out, 1: block accepts a pixel this cycle.
- pix_data, in, PIX_W: pixel, raster order (row 0 col 0 ... row 7 col 7).
- coef_valid, out, 1: coef_data is valid.
- coef_ready, in, 1: downstream accepts a coefficient.
- coef_data, out, COEF_W: coefficient F[k][l], k = vertical frequency (outer index), l = horizontal frequency.
- coef_last, out, 1: high with the 64th coefficient (F[7][7]).
- busy, out, 1: high in ROW, COL and OUT.

Behaviour:
- Clock and reset: one clock, sys_clk. sys_rst is asynchronous and active-high.
- Reset values: state=LOAD, pix_ready=0 while sys_rst is asserted, coef_valid=0, coef_last=0, coef_data=0, busy=0, all counters=0. A reset mid-operation discards the partial block. Buffer contents are don't-care after reset.
- Handshakes: a transfer happens when valid && ready on a rising edge. Both sides use valid/ready with no combinational ready-to-valid paths. coef_valid, once asserted, holds along with coef_data and coef_last until the transfer completes.
- State LOAD:
  - pix_ready=1.
  - Each accepted pixel is stored as s = pix_data - 128 (9-bit signed) at index 0..63.
  - After the 64th accept, go to ROW the next cycle.
- State ROW:
  - For r = 0..7 (outer) and u = 0..7 (inner): acc = sum over n = 0..7 of s[r][n] * COS[u][n].
  - One product per cycle, 8 MAC cycles, then 1 writeback cycle: T[r][u] = (acc + 2^14) >>> 15.
  - Each T is stored as 16-bit signed. The pass takes 576 cycles, then go to COL.
- State COL:
  - For l = 0..7 (outer) and k = 0..7 (inner): acc = sum over m = 0..7 of T[m][l] * COS[k][m].
  - Same 9-cycle cadence. F[k][l] = (acc + 2^14) >>> 15, saturated to [-2048, 2047] and sign-extended to COEF_W.
  - The pass takes 576 cycles, then go to OUT.
- State OUT:
  - Present F in raster order, k outer and l inner, one per transfer. coef_last is high on F[7][7].
  - After the last transfer, go to LOAD; pix_ready rises the following cycle.
  - coef_ready low stalls indefinitely with no data loss.
- Cosine table COS[u][n]:
  - Row u=0 is 11585 for every n. This folds C(0) = 1/sqrt2.
  - Rows u>0 are round(16384 * cos((2n+1)u*pi/16)), giving the values 16069, 15137, 13623, 11585, 9102, 6270, 3196 with the standard signs.
  - The >>>15 folds the 1/2 factor of each 1-D pass.
- Arithmetic widths: the accumulator is 32-bit signed. Rounding is add 2^14 then arithmetic shift right (round half toward +inf). There is no overflow internally.
- Latency: first coefficient valid at 64 accepts + 1152 compute cycles + 1 cycle. Throughput is one block per about 1281 cycles without stalls.
- Pixels presented outside LOAD are ignored (pix_ready=0).

Decomposition:
- dct_pkg: the COS table (shared with the IDCT), COS_FRAC, the round constant, the state enum typedef (LOAD, ROW, COL, OUT), and the block-size constant N=8.
- Sub-module dct_mac: 16x16 signed multiply, 32-bit accumulate, clear, and round/shift/saturate output. It is reused for both passes.

Test Plan:
- All pixels 128 -> all 64 coefficients 0; coef_last only on the 64th output.
- All pixels 255 -> F[0][0] = 1015, other 63 coefficients = 0.
- All pixels 0 -> F[0][0] = -1024, others 0 (checks negative rounding: row T = -362).
- Random blocks (at least 200) against a double-precision reference DCT -> every coefficient within +/-2; coef_ready toggled randomly, no loss or duplication, outputs held while stalled.
- Assert sys_rst after 30 pixels, deassert, send a full all-255 block -> outputs match the all-255 case; coef_valid stays 0 during reset.
- Back-to-back blocks with pix_valid held high -> pix_ready=0 during ROW/COL/OUT, no pixel is accepted early, and the second block's result is correct.
